mtm_alu_deserializer: RTL and testbench

Input stage of the serial ALU. It samples the 1-bit serial line `sin` once per `clk` and assembles 11-bit packets into a frame. A frame is 8 data packets (A then B) followed by 1 command packet. It checks the frame and presents A, B, op and error flags to the ALU core as a one-cycle `out_valid` strobe.

---
 rtl/mtm_alu_deserializer.sv | 169 ++++++++++++++++
 tb/tb_mtm_alu_deserializer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer: serial input stage of the MTM ALU.
// Samples one bit of `sin` per clock, assembles 11-bit packets into a
// frame of 8 data packets plus 1 command packet, checks count/CRC/op and
// presents the result with a one-cycle out_valid strobe.
// Optional build macro: MTM_DESER_TIMEOUT_EN aborts a partial frame after
// TIMEOUT_CYCLES idle cycles between packets and pulses err_timeout.
module mtm_alu_deserializer #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic        out_valid,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [2:0]  out_op,
    output logic        err_data,
    output logic        err_crc,
    output logic        err_op,
    output logic        err_timeout
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] TYPE    = 3'd1;
    localparam logic [2:0] PAYLOAD = 3'd2;
    localparam logic [2:0] STOP    = 3'd3;
    localparam logic [2:0] DRAIN   = 3'd4;

    logic [2:0]  state;
    logic        is_cmd;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic [3:0]  data_cnt;
    logic        overflow;
    logic [63:0] ab;

    logic [2:0]  cmd_op;
    logic [3:0]  cmd_crc;
    logic [67:0] crc_msg;
    logic        crc_fb;
    logic [3:0]  crc_calc;
    logic        bad_count;
    logic        crc_bad;
    logic        timeout_hit;

    // Command payload is {ignored, op[2:0], crc[3:0]}
    assign cmd_op    = shift[6:4];
    assign cmd_crc   = shift[3:0];
    assign bad_count = (data_cnt != 4'd8) || overflow;
    assign crc_bad   = (crc_calc != cmd_crc);

    // CRC-4 (x^4+x+1, init 0) over {A, B, 1'b1, op}, MSB first
    always_comb begin
        crc_msg  = {ab, 1'b1, cmd_op};
        crc_calc = '0;
        crc_fb   = 1'b0;
        for (int unsigned i = 0; i < 68; i++) begin
            crc_fb   = crc_calc[3] ^ crc_msg[67 - i];
            crc_calc = {crc_calc[2:0], 1'b0} ^ {2'b00, crc_fb, crc_fb};
        end
    end

`ifdef MTM_DESER_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt;

    // Abort fires on the idle cycle that brings the count to TIMEOUT_CYCLES
    assign timeout_hit = (state == IDLE) && sin && (data_cnt != '0) &&
                         (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    // Idle-gap counter between packets of a partially received frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= timeout_hit;
            if ((state == IDLE) && sin && (data_cnt != '0) && !timeout_hit)
                idle_cnt <= idle_cnt + IDLE_W'(1);
            else
                idle_cnt <= '0;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign err_timeout        = 1'b0;
`endif

    // Packet FSM, frame assembly and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            is_cmd    <= 1'b0;
            bit_cnt   <= '0;
            shift     <= '0;
            data_cnt  <= '0;
            overflow  <= 1'b0;
            ab        <= '0;
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_op    <= '0;
            err_data  <= 1'b0;
            err_crc   <= 1'b0;
            err_op    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!sin) begin
                        state <= TYPE;
                    end else if (timeout_hit) begin
                        data_cnt <= '0;
                        overflow <= 1'b0;
                    end
                end
                TYPE: begin
                    is_cmd  <= sin;
                    bit_cnt <= 3'd7;
                    state   <= PAYLOAD;
                end
                PAYLOAD: begin
                    shift <= {shift[6:0], sin};
                    if (bit_cnt == 3'd0)
                        state <= STOP;
                    else
                        bit_cnt <= bit_cnt - 3'd1;
                end
                STOP: begin
                    if (!sin) begin
                        data_cnt <= '0;
                        overflow <= 1'b0;
                        state    <= DRAIN;
                    end else begin
                        state <= IDLE;
                        if (!is_cmd) begin
                            if (data_cnt < 4'd8) begin
                                ab       <= {ab[55:0], shift};
                                data_cnt <= data_cnt + 4'd1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else begin
                            out_valid <= 1'b1;
                            out_a     <= ab[63:32];
                            out_b     <= ab[31:0];
                            out_op    <= cmd_op;
                            err_data  <= bad_count;
                            err_crc   <= !bad_count && crc_bad;
                            err_op    <= !bad_count && !crc_bad && cmd_op[1];
                            data_cnt  <= '0;
                            overflow  <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (sin)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Scoreboard bench for mtm_alu_deserializer: stimulus pushes hand-computed
// expected frame results, a negedge monitor pops and compares on out_valid.
`timescale 1ns/1ps
module tb_mtm_alu_deserializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sin = 1'b1;
    logic        out_valid;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [2:0]  out_op;
    logic        err_data;
    logic        err_crc;
    logic        err_op;
    logic        err_timeout;

    mtm_alu_deserializer #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .sin         (sin),
        .out_valid   (out_valid),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_op      (out_op),
        .err_data    (err_data),
        .err_crc     (err_crc),
        .err_op      (err_op),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests   = 0;
    int fails   = 0;
    int exp_to  = 0;
    int seen_to = 0;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        ed;
        logic        ec;
        logic        eo;
        bit          chk_ab;
        int          due;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare every strobe against the oldest expected frame
    always @(negedge clk) begin
        if (err_timeout) begin
            seen_to++;
            check("timeout_pulse_expected", 64'(seen_to <= exp_to), 64'd1);
        end
        if (out_valid) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_out_valid: actual 1 required 0 (cycle %0d)", cyc);
            end else begin
                mon_e = sbq.pop_front();
                check($sformatf("f%0d_latency_cycle", mon_e.id), 64'(cyc), 64'(mon_e.due));
                check($sformatf("f%0d_err_data", mon_e.id), 64'(err_data), 64'(mon_e.ed));
                check($sformatf("f%0d_err_crc", mon_e.id), 64'(err_crc), 64'(mon_e.ec));
                check($sformatf("f%0d_err_op", mon_e.id), 64'(err_op), 64'(mon_e.eo));
                check($sformatf("f%0d_out_op", mon_e.id), 64'(out_op), 64'(mon_e.op));
                if (mon_e.chk_ab) begin
                    check($sformatf("f%0d_out_a", mon_e.id), 64'(out_a), 64'(mon_e.a));
                    check($sformatf("f%0d_out_b", mon_e.id), 64'(out_b), 64'(mon_e.b));
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        sin = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) send_bit(1'b1);
    endtask

    task automatic send_packet(input logic typ, input logic [7:0] pay, input logic stop_bit);
        send_bit(1'b0);
        send_bit(typ);
        for (int i = 7; i >= 0; i--) send_bit(pay[i]);
        send_bit(stop_bit);
    endtask

    task automatic send_ab(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] v;
        v = {a, b};
        for (int i = 0; i < 8; i++) send_packet(1'b0, v[63 - 8*i -: 8], 1'b1);
    endtask

    // Sends the command packet and queues the result due one cycle later
    task automatic send_cmd(input logic [7:0] pay, input int id,
                            input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                            input logic ed, input logic ec, input logic eo, input bit chk);
        exp_t e;
        send_packet(1'b1, pay, 1'b1);
        e.id = id; e.a = a; e.b = b; e.op = op;
        e.ed = ed; e.ec = ec; e.eo = eo; e.chk_ab = chk; e.due = cyc;
        sbq.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_a"}, 64'(out_a), 64'd0);
        check({tag, "_out_b"}, 64'(out_b), 64'd0);
        check({tag, "_out_op"}, 64'(out_op), 64'd0);
        check({tag, "_err_flags"}, 64'({err_data, err_crc, err_op, err_timeout}), 64'd0);
    endtask

    initial begin
        logic [63:0] v;

        rst = 1'b1;
        sin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        idle(2);

        // Zero operands, CRC 1011: clean result
        send_ab(32'd0, 32'd0);
        send_cmd(8'h0B, 1, 32'd0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        // Same frame, wrong CRC; starts in the out_valid cycle of frame 1
        send_ab(32'd0, 32'd0);
        send_cmd(8'h0A, 2, 32'd0, 32'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
        // op=010 with correct CRC 0110: invalid op
        send_ab(32'd10, 32'd20);
        send_cmd(8'h26, 3, 32'd10, 32'd20, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1);
        // op=001, CRC 0011, payload bit 7 set and ignored
        send_ab(32'h8000_0000, 32'h0000_0001);
        send_cmd(8'h93, 4, 32'h8000_0000, 32'h0000_0001, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        // op=101, CRC 0100
        send_ab(32'd0, 32'd0);
        send_cmd(8'h54, 5, 32'd0, 32'd0, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1);

        // 7 data packets: err_data wins over the bad CRC
        for (int i = 0; i < 7; i++) send_packet(1'b0, 8'(i * 17 + 3), 1'b1);
        send_cmd(8'h0A, 6, 32'd0, 32'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        // 9 data packets: err_data wins over the bad op
        for (int i = 0; i < 9; i++) send_packet(1'b0, 8'hA5, 1'b1);
        send_cmd(8'h26, 7, 32'd0, 32'd0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
        // Recovery after overflow: op=100, CRC 1100
        send_ab(32'd10, 32'd20);
        send_cmd(8'h4C, 8, 32'd10, 32'd20, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1);
        // Command with no data
        send_cmd(8'h0B, 9, 32'd0, 32'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);

        // Framing error in data packet 3, then a clean frame
        send_packet(1'b0, 8'h12, 1'b1);
        send_packet(1'b0, 8'h34, 1'b1);
        send_packet(1'b0, 8'h56, 1'b0);
        idle(3);
        send_ab(32'd10, 32'd20);
        send_cmd(8'h4C, 10, 32'd10, 32'd20, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1);

        // Long gap after 4 data packets
        v = {32'd10, 32'd20};
        for (int i = 0; i < 4; i++) send_packet(1'b0, v[63 - 8*i -: 8], 1'b1);
`ifdef MTM_DESER_TIMEOUT_EN
        exp_to++;
        idle(20);
        check("timeout_pulse_count", 64'(seen_to), 64'(exp_to));
        send_ab(32'd10, 32'd20);
        send_cmd(8'h4C, 11, 32'd10, 32'd20, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1);
`else
        idle(20);
        check("timeout_pulse_count", 64'(seen_to), 64'(exp_to));
        for (int i = 4; i < 8; i++) send_packet(1'b0, v[63 - 8*i -: 8], 1'b1);
        send_cmd(8'h4C, 11, 32'd10, 32'd20, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // Frame with non-zero outputs so the reset clear is observable
        send_ab(32'd10, 32'd20);
        send_cmd(8'h26, 12, 32'd10, 32'd20, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Reset in the middle of data packet 5
        for (int i = 0; i < 4; i++) send_packet(1'b0, 8'hC3, 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        send_ab(32'h8000_0000, 32'h0000_0001);
        send_cmd(8'h93, 13, 32'h8000_0000, 32'h0000_0001, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);

        idle(5);
        check("all_frames_seen", 64'(sbq.size()), 64'd0);
        check("timeout_pulse_total", 64'(seen_to), 64'(exp_to));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: actual timeout required completion (cycle %0d)", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
